mem_port_arbiter: RTL and testbench

- Shares the CPU's single memory port between the instruction fetcher (read-only) and the load/store queue (read/write).
- Grants one requester at a time and latches the granted request onto the memory port. Holds it there until mem_resp, then routes the response back to the owner.
- Data side has priority by default; a starvation counter forces a fetch grant after a bounded number of consecutive data grants.

---
 rtl/mem_port_arbiter_if.sv | 35 +++
 rtl/mem_port_arbiter.sv | 105 ++++++++++
 tb/tb_mem_port_arbiter.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester and memory-side signals of the shared memory port.
// Parameter width sets the address/data width; byte enables are width/8 bits.
// slave modport: the arbiter's view. It sees the fetch (i_*) and LSQ (d_*)
// requests plus mem_resp/mem_rdata, and drives the responses and mem_* strobes.
// master modport: the requester/memory view, with every direction reversed.
interface mem_port_arbiter_if #(parameter int width = 32);
    logic                 i_read;
    logic [width-1:0]     i_addr;
    logic                 i_resp;
    logic [width-1:0]     i_rdata;
    logic                 d_read;
    logic                 d_write;
    logic [width-1:0]     d_addr;
    logic [width-1:0]     d_wdata;
    logic [width/8-1:0]   d_byte_enable;
    logic                 d_resp;
    logic [width-1:0]     d_rdata;
    logic                 mem_read;
    logic                 mem_write;
    logic [width/8-1:0]   mem_byte_enable;
    logic [width-1:0]     mem_address;
    logic [width-1:0]     mem_wdata;
    logic                 mem_resp;
    logic [width-1:0]     mem_rdata;

    modport slave (
        input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, d_byte_enable, mem_resp, mem_rdata,
        output i_resp, i_rdata, d_resp, d_rdata, mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata
    );

    modport master (
        output i_read, i_addr, d_read, d_write, d_addr, d_wdata, d_byte_enable, mem_resp, mem_rdata,
        input  i_resp, i_rdata, d_resp, d_rdata, mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between the instruction fetcher and the LSQ.
// Ports:
//   clk, rst (asynchronous, active-low)
//   bus  : mem_port_arbiter_if.slave (fetch, LSQ and memory-side signals)
//   busy : high while a transaction owns the port
//   i_flush (only with MEM_ARB_FLUSH_EN): squashes an in-flight fetch
//     response and blocks a fetch grant in IDLE.
// Data has priority. After STARVE_LIMIT consecutive data grants taken while a
// fetch waits, the fetch is granted.
module mem_port_arbiter #(
    parameter int width        = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                   clk,
    input  logic                   rst,
`ifdef MEM_ARB_FLUSH_EN
    input  logic                   i_flush,
`endif
    mem_port_arbiter_if.slave      bus,
    output logic                   busy
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   starve_cnt;
    logic            fetch_req, grant_d, grant_i, done, i_ok;

`ifdef MEM_ARB_FLUSH_EN
    logic squash;
    assign fetch_req = bus.i_read & ~i_flush;
    assign i_ok      = ~squash & ~i_flush;
`else
    assign fetch_req = bus.i_read;
    assign i_ok      = 1'b1;
`endif

    assign grant_d = state == IDLE && (bus.d_read | bus.d_write) && (!fetch_req || starve_cnt < LIM);
    assign grant_i = state == IDLE && !grant_d && fetch_req;
    assign done    = bus.mem_resp && state != IDLE;

    always_comb begin
        state_n = state;
        state_n = grant_d ? D_BUSY : grant_i ? I_BUSY : done ? IDLE : state;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
        end else begin
            state <= state_n;
            if (grant_i)
                starve_cnt <= '0;
            else if (grant_d)
                starve_cnt <= !fetch_req ? '0 : starve_cnt == LIM ? LIM : starve_cnt + CW'(1);
        end
    end

    // Request fields are captured once at grant so the port stays stable for the transaction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.mem_read        <= 1'b0;
            bus.mem_write       <= 1'b0;
            bus.mem_byte_enable <= '0;
            bus.mem_address     <= '0;
            bus.mem_wdata       <= '0;
        end else if (grant_i) begin
            bus.mem_read        <= 1'b1;
            bus.mem_write       <= 1'b0;
            bus.mem_byte_enable <= '1;
            bus.mem_address     <= bus.i_addr;
            bus.mem_wdata       <= '0;
        end else if (grant_d) begin
            bus.mem_read        <= ~bus.d_write;
            bus.mem_write       <= bus.d_write;
            bus.mem_byte_enable <= bus.d_byte_enable;
            bus.mem_address     <= bus.d_addr;
            bus.mem_wdata       <= bus.d_wdata;
        end else if (done) begin
            bus.mem_read        <= 1'b0;
            bus.mem_write       <= 1'b0;
        end
    end

`ifdef MEM_ARB_FLUSH_EN
    // The squash flag clears on mem_resp; a flush arriving in that same cycle is still honoured via i_ok.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            squash <= 1'b0;
        else if (done)
            squash <= 1'b0;
        else if (state == I_BUSY && i_flush)
            squash <= 1'b1;
    end
`endif

    assign bus.i_resp  = bus.mem_resp && state == I_BUSY && i_ok;
    assign bus.d_resp  = bus.mem_resp && state == D_BUSY;
    assign bus.i_rdata = bus.mem_rdata;
    assign bus.d_rdata = bus.mem_rdata;
    assign busy        = state != IDLE;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_mem_port_arbiter;
    localparam int W   = 32;
    localparam int LIM = 4;

    logic clk = 1'b0;
    logic rst;
    logic busy;
`ifdef MEM_ARB_FLUSH_EN
    logic i_flush;
`endif
    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.width(W)) bus();

    mem_port_arbiter #(.width(W), .STARVE_LIMIT(LIM)) dut (
        .clk(clk),
        .rst(rst),
`ifdef MEM_ARB_FLUSH_EN
        .i_flush(i_flush),
`endif
        .bus(bus),
        .busy(busy)
    );

    // Model state for the random test: pending requests and the run of data grants while a fetch waits.
    logic            ip, dp, dw, dboth;
    logic [W-1:0]    ia, da, dwd;
    logic [W/8-1:0]  dbe;
    int              streak;

    task automatic idle_inputs();
        bus.i_read = 0; bus.i_addr = '0;
        bus.d_read = 0; bus.d_write = 0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_byte_enable = '0;
        bus.mem_resp = 0; bus.mem_rdata = '0;
`ifdef MEM_ARB_FLUSH_EN
        i_flush = 0;
`endif
    endtask

    task automatic do_reset();
        rst = 0;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst = 1;
        @(negedge clk);
    endtask

    task automatic drive_model();
        bus.i_read = ip; bus.i_addr = ia;
        bus.d_write = dp & dw; bus.d_read = dp & (~dw | dboth);
        bus.d_addr = da; bus.d_wdata = dwd; bus.d_byte_enable = dbe;
    endtask

    task automatic test_reset();
        rst = 0;
        idle_inputs();
        bus.i_read = 1; bus.d_write = 1;
        #1;
        total++; if (bus.mem_read !== 1'b0) $display("FAIL reset_mem_read got %0h want 0", bus.mem_read); else passed++;
        total++; if (bus.mem_write !== 1'b0) $display("FAIL reset_mem_write got %0h want 0", bus.mem_write); else passed++;
        total++; if (bus.mem_address !== '0) $display("FAIL reset_mem_address got %0h want 0", bus.mem_address); else passed++;
        total++; if (bus.mem_wdata !== '0) $display("FAIL reset_mem_wdata got %0h want 0", bus.mem_wdata); else passed++;
        total++; if (bus.mem_byte_enable !== '0) $display("FAIL reset_mem_be got %0h want 0", bus.mem_byte_enable); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got %0h want 0", busy); else passed++;
        @(negedge clk);
        do_reset();
    endtask

    task automatic test_single_fetch();
        do_reset();
        bus.i_addr = 32'h60; bus.i_read = 1;
        @(negedge clk);
        total++; if (bus.mem_read !== 1'b1) $display("FAIL fetch_mem_read got %0h want 1", bus.mem_read); else passed++;
        total++; if (bus.mem_address !== 32'h60) $display("FAIL fetch_addr got %0h want 60", bus.mem_address); else passed++;
        total++; if (bus.mem_byte_enable !== 4'hF) $display("FAIL fetch_be got %0h want f", bus.mem_byte_enable); else passed++;
        total++; if (bus.mem_wdata !== '0) $display("FAIL fetch_wdata got %0h want 0", bus.mem_wdata); else passed++;
        repeat (3) begin
            @(negedge clk);
            total++; if (bus.i_resp !== 1'b0 || bus.mem_read !== 1'b1) $display("FAIL fetch_wait got resp=%0h rd=%0h want 0/1", bus.i_resp, bus.mem_read); else passed++;
        end
        bus.mem_rdata = 32'h13; bus.mem_resp = 1;
        #1;
        total++; if (bus.i_resp !== 1'b1) $display("FAIL fetch_i_resp got %0h want 1", bus.i_resp); else passed++;
        total++; if (bus.i_rdata !== 32'h13) $display("FAIL fetch_i_rdata got %0h want 13", bus.i_rdata); else passed++;
        total++; if (bus.d_resp !== 1'b0) $display("FAIL fetch_d_resp got %0h want 0", bus.d_resp); else passed++;
        bus.i_read = 0;
        @(negedge clk);
        bus.mem_resp = 0;
        #1;
        total++; if (bus.i_resp !== 1'b0 || bus.mem_read !== 1'b0 || busy !== 1'b0) $display("FAIL fetch_done got resp=%0h rd=%0h busy=%0h want 0/0/0", bus.i_resp, bus.mem_read, busy); else passed++;
    endtask

    task automatic test_contention();
        do_reset();
        bus.i_addr = 32'h64; bus.i_read = 1; bus.d_addr = 32'h1000; bus.d_read = 1;
        @(negedge clk);
        total++; if (bus.mem_address !== 32'h1000 || bus.mem_read !== 1'b1) $display("FAIL cont_first got addr=%0h rd=%0h want 1000/1", bus.mem_address, bus.mem_read); else passed++;
        @(negedge clk);
        bus.mem_rdata = 32'hAA; bus.mem_resp = 1;
        #1;
        total++; if (bus.d_resp !== 1'b1 || bus.i_resp !== 1'b0 || bus.d_rdata !== 32'hAA) $display("FAIL cont_d_resp got d=%0h i=%0h data=%0h want 1/0/aa", bus.d_resp, bus.i_resp, bus.d_rdata); else passed++;
        bus.d_read = 0;
        @(negedge clk);
        bus.mem_resp = 0;
        #1;
        total++; if (busy !== 1'b0) $display("FAIL cont_idle_gap got busy=%0h want 0", busy); else passed++;
        @(negedge clk);
        total++; if (bus.mem_address !== 32'h64 || bus.mem_read !== 1'b1) $display("FAIL cont_second got addr=%0h rd=%0h want 64/1", bus.mem_address, bus.mem_read); else passed++;
        bus.mem_rdata = 32'hBB; bus.mem_resp = 1;
        #1;
        total++; if (bus.i_resp !== 1'b1 || bus.d_resp !== 1'b0 || bus.i_rdata !== 32'hBB) $display("FAIL cont_i_resp got i=%0h d=%0h data=%0h want 1/0/bb", bus.i_resp, bus.d_resp, bus.i_rdata); else passed++;
        bus.i_read = 0;
        @(negedge clk);
        bus.mem_resp = 0;
    endtask

    task automatic test_starvation();
        int dgrants = 0;
        logic fetched = 0;
        do_reset();
        bus.i_addr = 32'h80; bus.i_read = 1;
        bus.d_addr = 32'h3000; bus.d_wdata = 32'h5; bus.d_byte_enable = 4'hF; bus.d_write = 1;
        for (int k = 0; k < 8 && !fetched; k++) begin
            @(negedge clk);
            if (bus.mem_read === 1'b1 && bus.mem_address === 32'h80) begin
                fetched = 1;
                bus.i_read = 0;
            end else if (bus.mem_write === 1'b1) begin
                dgrants++;
            end
            bus.mem_resp = 1;
            @(negedge clk);
            bus.mem_resp = 0;
        end
        total++; if (fetched !== 1'b1) $display("FAIL starve_fetch got fetched=%0h want 1", fetched); else passed++;
        total++; if (dgrants != LIM) $display("FAIL starve_dgrants got %0d want %0d", dgrants, LIM); else passed++;
        total++; if (dut.starve_cnt !== '0) $display("FAIL starve_cnt got %0d want 0", dut.starve_cnt); else passed++;
        @(negedge clk);
        total++; if (bus.mem_write !== 1'b1) $display("FAIL starve_next_data got wr=%0h want 1", bus.mem_write); else passed++;
        bus.d_write = 0; bus.mem_resp = 1;
        @(negedge clk);
        bus.mem_resp = 0;
    endtask

    task automatic test_write_latch();
        do_reset();
        bus.d_addr = 32'h2004; bus.d_wdata = 32'hDEADBEEF; bus.d_byte_enable = 4'b0011; bus.d_write = 1;
        @(negedge clk);
        total++; if (bus.mem_write !== 1'b1 || bus.mem_read !== 1'b0 || bus.mem_address !== 32'h2004) $display("FAIL wr_grant got wr=%0h rd=%0h addr=%0h want 1/0/2004", bus.mem_write, bus.mem_read, bus.mem_address); else passed++;
        bus.d_wdata = '0; bus.d_byte_enable = 4'hF;
        repeat (2) begin
            @(negedge clk);
            total++; if (bus.mem_wdata !== 32'hDEADBEEF || bus.mem_byte_enable !== 4'b0011) $display("FAIL wr_hold got data=%0h be=%0h want deadbeef/3", bus.mem_wdata, bus.mem_byte_enable); else passed++;
        end
        bus.mem_resp = 1;
        #1;
        total++; if (bus.d_resp !== 1'b1) $display("FAIL wr_d_resp got %0h want 1", bus.d_resp); else passed++;
        bus.d_write = 0;
        @(negedge clk);
        bus.mem_resp = 0;
        #1;
        total++; if (bus.mem_write !== 1'b0 || bus.d_resp !== 1'b0) $display("FAIL wr_done got wr=%0h resp=%0h want 0/0", bus.mem_write, bus.d_resp); else passed++;
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        bus.d_addr = 32'h10; bus.d_write = 1;
        @(negedge clk);
        total++; if (bus.mem_write !== 1'b1) $display("FAIL rmid_grant got %0h want 1", bus.mem_write); else passed++;
        #2 rst = 0;
        #1;
        total++; if (bus.mem_write !== 1'b0 || busy !== 1'b0) $display("FAIL rmid_async got wr=%0h busy=%0h want 0/0", bus.mem_write, busy); else passed++;
        idle_inputs();
        @(negedge clk);
        rst = 1;
        bus.mem_resp = 1;
        #1;
        total++; if (bus.d_resp !== 1'b0 || bus.i_resp !== 1'b0) $display("FAIL rmid_late_resp got d=%0h i=%0h want 0/0", bus.d_resp, bus.i_resp); else passed++;
        @(negedge clk);
        bus.mem_resp = 0;
        total++; if (busy !== 1'b0) $display("FAIL rmid_state got busy=%0h want 0", busy); else passed++;
    endtask

`ifdef MEM_ARB_FLUSH_EN
    task automatic test_flush();
        do_reset();
        bus.i_addr = 32'h90; bus.i_read = 1;
        @(negedge clk);
        i_flush = 1;
        @(negedge clk);
        i_flush = 0;
        total++; if (bus.mem_read !== 1'b1) $display("FAIL flush_hold got %0h want 1", bus.mem_read); else passed++;
        bus.mem_resp = 1;
        #1;
        total++; if (bus.i_resp !== 1'b0) $display("FAIL flush_squash got %0h want 0", bus.i_resp); else passed++;
        bus.i_read = 0;
        @(negedge clk);
        bus.mem_resp = 0;
        bus.i_addr = 32'h94; bus.i_read = 1; i_flush = 1;
        @(negedge clk);
        total++; if (busy !== 1'b0) $display("FAIL flush_idle_block got busy=%0h want 0", busy); else passed++;
        i_flush = 0;
        @(negedge clk);
        total++; if (bus.mem_read !== 1'b1 || bus.mem_address !== 32'h94) $display("FAIL flush_refetch got rd=%0h addr=%0h want 1/94", bus.mem_read, bus.mem_address); else passed++;
        bus.mem_resp = 1;
        #1;
        total++; if (bus.i_resp !== 1'b1) $display("FAIL flush_next_resp got %0h want 1", bus.i_resp); else passed++;
        bus.i_read = 0;
        @(negedge clk);
        bus.mem_resp = 0;
    endtask
`endif

    task automatic test_random();
        logic dg, ig;
        logic [W-1:0] rd, exp_addr;
        do_reset();
        ip = 0; dp = 0; dw = 0; dboth = 0; ia = '0; da = '0; dwd = '0; dbe = '0; streak = 0;
        for (int n = 0; n < 80; n++) begin
            if (!ip && $urandom_range(1) == 1) begin ip = 1; ia = $urandom; end
            if (!dp && $urandom_range(1) == 1) begin
                dp = 1; dw = 1'($urandom_range(1)); dboth = ($urandom_range(3) == 0);
                da = $urandom; dwd = $urandom; dbe = 4'($urandom);
            end
            drive_model();
            bus.mem_resp = ($urandom_range(3) == 0);
            #1;
            total++; if (bus.i_resp !== 1'b0 || bus.d_resp !== 1'b0) $display("FAIL rnd_idle_resp n=%0d got i=%0h d=%0h want 0/0", n, bus.i_resp, bus.d_resp); else passed++;
            dg = dp && (!ip || streak < LIM);
            ig = !dg && ip;
            @(negedge clk);
            bus.mem_resp = 0;
            if (!dg && !ig) begin
                total++; if (busy !== 1'b0) $display("FAIL rnd_no_grant n=%0d got busy=%0h want 0", n, busy); else passed++;
                continue;
            end
            exp_addr = dg ? da : ia;
            total++; if (busy !== 1'b1 || bus.mem_address !== exp_addr) $display("FAIL rnd_grant n=%0d got busy=%0h addr=%0h want 1/%0h", n, busy, bus.mem_address, exp_addr); else passed++;
            total++; if (bus.mem_write !== (dg & dw) || bus.mem_read !== (ig | (dg & ~dw))) $display("FAIL rnd_strobe n=%0d got wr=%0h rd=%0h want %0h/%0h", n, bus.mem_write, bus.mem_read, dg & dw, ig | (dg & ~dw)); else passed++;
            total++; if (bus.mem_byte_enable !== (dg ? dbe : 4'hF) || bus.mem_wdata !== (dg ? dwd : '0)) $display("FAIL rnd_fields n=%0d got be=%0h data=%0h", n, bus.mem_byte_enable, bus.mem_wdata); else passed++;
            streak = (dg && ip) ? ((streak + 1 > LIM) ? LIM : streak + 1) : 0;
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                total++; if (bus.mem_address !== exp_addr || bus.i_resp !== 1'b0 || bus.d_resp !== 1'b0) $display("FAIL rnd_wait n=%0d got addr=%0h i=%0h d=%0h", n, bus.mem_address, bus.i_resp, bus.d_resp); else passed++;
            end
            rd = $urandom;
            bus.mem_rdata = rd; bus.mem_resp = 1;
            #1;
            total++; if (bus.i_resp !== ig || bus.d_resp !== dg) $display("FAIL rnd_resp n=%0d got i=%0h d=%0h want %0h/%0h", n, bus.i_resp, bus.d_resp, ig, dg); else passed++;
            total++; if ((dg ? bus.d_rdata : bus.i_rdata) !== rd) $display("FAIL rnd_rdata n=%0d got %0h want %0h", n, dg ? bus.d_rdata : bus.i_rdata, rd); else passed++;
            if (ig) begin ip = 1'($urandom_range(1)); ia = $urandom; end
            else begin dp = 1'($urandom_range(1)); dw = 1'($urandom_range(1)); dboth = 0; da = $urandom; dwd = $urandom; dbe = 4'($urandom); end
            drive_model();
            @(negedge clk);
            bus.mem_resp = 0;
            total++; if (busy !== 1'b0 || bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) $display("FAIL rnd_done n=%0d got busy=%0h rd=%0h wr=%0h want 0/0/0", n, busy, bus.mem_read, bus.mem_write); else passed++;
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_contention();
        test_starvation();
        test_write_latch();
        test_reset_mid_op();
`ifdef MEM_ARB_FLUSH_EN
        test_flush();
`endif
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
